// File: rtl/vend_pkg.sv
// Shared coin encodings, coin-to-units conversion and controller state type
// for the vending transaction controller.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_25   = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    CREDIT   = 2'b01,
    DISPENSE = 2'b10,
    CHANGE   = 2'b11
  } vend_state_e;

  function automatic logic [4:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  coin_value = 5'd5;
      COIN_10: coin_value = 5'd10;
      COIN_25: coin_value = 5'd25;
      default: coin_value = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_sel.sv
// Greedy change selector: picks the largest coin (25, 10, 5) not exceeding
// the given credit, returning its code and value in units.
module vend_change_sel
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] i_credit,
  output logic [1:0]          o_coin,
  output logic [4:0]          o_value
);

  // Largest denomination that still fits in the remaining credit
  always_comb begin
    o_coin  = COIN_NONE;
    o_value = 5'd0;
    if (i_credit >= CREDIT_W'(25)) begin
      o_coin  = COIN_25;
      o_value = 5'd25;
    end else if (i_credit >= CREDIT_W'(10)) begin
      o_coin  = COIN_10;
      o_value = 5'd10;
    end else if (i_credit >= CREDIT_W'(5)) begin
      o_coin  = COIN_5;
      o_value = 5'd5;
    end else begin
      o_coin  = COIN_NONE;
      o_value = 5'd0;
    end
  end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vend transaction controller: credit accumulation, selection, dispense handshake
// and greedy change payout. Idle auto-refund is built only with VEND_TIMEOUT_EN.
module vend_txn_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE       = 30,
  parameter int MAX_CREDIT  = 100,
  parameter int CREDIT_W    = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin,
  output logic                coin_accept,
  output logic                coin_reject,
  input  logic                sel,
  output logic                sel_nak,
  input  logic                cancel,
  output logic                disp_req,
  input  logic                disp_ack,
  output logic                chg_valid,
  output logic [1:0]          chg_coin,
  input  logic                chg_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  if (PRICE > MAX_CREDIT || TIMEOUT_CYC < 1 || MAX_CREDIT >= (1 << CREDIT_W)) begin : g_param_chk
    $error("vend_txn_ctrl: inconsistent PRICE/MAX_CREDIT/CREDIT_W/TIMEOUT_CYC");
  end

  vend_state_e         r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_coin_accept, r_coin_reject, r_sel_nak;
  logic                r_disp_req, r_chg_valid, r_busy;
  logic [1:0]          r_chg_coin;
  logic [4:0]          r_chg_val;

  vend_state_e         w_state_nxt;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic                w_coin_acc, w_coin_rej, w_sel_nak;
  logic [4:0]          w_coin_val;
  logic [CREDIT_W:0]   w_sum;
  logic                w_coin_ok;
  logic [1:0]          w_sel_coin;
  logic [4:0]          w_sel_val;

`ifdef VEND_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] r_tmo_cnt;
`endif

  assign w_coin_val = coin_value(coin);
  assign w_sum      = {1'b0, r_credit} + (CREDIT_W + 1)'(w_coin_val);
  assign w_coin_ok  = coin_valid && (coin != COIN_NONE) && (w_sum <= (CREDIT_W + 1)'(MAX_CREDIT));

  // Change coin for the next cycle is chosen from the post-edge credit so it registers with it
  vend_change_sel #(.CREDIT_W(CREDIT_W)) u_chg_sel (
    .i_credit (w_credit_nxt),
    .o_coin   (w_sel_coin),
    .o_value  (w_sel_val)
  );

  // Next state/credit and the event pulses; priority is cancel > successful sel > coin
  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_coin_acc   = 1'b0;
    w_coin_rej   = 1'b0;
    w_sel_nak    = 1'b0;
    case (r_state)
      IDLE, CREDIT: begin
        if (cancel) begin
          w_coin_rej  = coin_valid;
          w_state_nxt = (r_state == CREDIT) ? CHANGE : r_state;
        end else if (sel && (r_credit >= CREDIT_W'(PRICE))) begin
          w_coin_rej   = coin_valid;
          w_credit_nxt = r_credit - CREDIT_W'(PRICE);
          w_state_nxt  = DISPENSE;
        end else begin
          w_sel_nak = sel;
          if (w_coin_ok) begin
            w_coin_acc   = 1'b1;
            w_credit_nxt = w_sum[CREDIT_W-1:0];
          end else begin
            w_coin_rej = coin_valid;
          end
          w_state_nxt = (w_credit_nxt != {CREDIT_W{1'b0}}) ? CREDIT : IDLE;
`ifdef VEND_TIMEOUT_EN
          w_state_nxt = (r_state == CREDIT && !coin_valid && !sel &&
                         r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) ? CHANGE : w_state_nxt;
`endif
        end
      end
      DISPENSE: begin
        w_coin_rej = coin_valid;
        if (disp_ack) begin
          w_state_nxt = (r_credit != {CREDIT_W{1'b0}}) ? CHANGE : IDLE;
        end else begin
          w_state_nxt = DISPENSE;
        end
      end
      CHANGE: begin
        w_coin_rej = coin_valid;
        if (r_chg_valid && chg_ready) begin
          w_credit_nxt = r_credit - CREDIT_W'(r_chg_val);
          w_state_nxt  = (w_credit_nxt == {CREDIT_W{1'b0}}) ? IDLE : CHANGE;
        end else begin
          w_state_nxt = CHANGE;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_credit_nxt = {CREDIT_W{1'b0}};
      end
    endcase
  end

  // State, credit and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_credit      <= {CREDIT_W{1'b0}};
      r_coin_accept <= 1'b0;
      r_coin_reject <= 1'b0;
      r_sel_nak     <= 1'b0;
      r_disp_req    <= 1'b0;
      r_chg_valid   <= 1'b0;
      r_chg_coin    <= COIN_NONE;
      r_chg_val     <= 5'd0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_credit      <= w_credit_nxt;
      r_coin_accept <= w_coin_acc;
      r_coin_reject <= w_coin_rej;
      r_sel_nak     <= w_sel_nak;
      r_disp_req    <= (w_state_nxt == DISPENSE);
      r_chg_valid   <= (w_state_nxt == CHANGE);
      r_chg_coin    <= (w_state_nxt == CHANGE) ? w_sel_coin : COIN_NONE;
      r_chg_val     <= (w_state_nxt == CHANGE) ? w_sel_val : 5'd0;
      r_busy        <= (w_state_nxt == DISPENSE) || (w_state_nxt == CHANGE);
    end
  end

`ifdef VEND_TIMEOUT_EN
  // Idle-cycle counter: only advances across quiet cycles that stay in CREDIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= {TMO_W{1'b0}};
    end else if (r_state == CREDIT && w_state_nxt == CREDIT && !coin_valid && !sel && !cancel) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end else begin
      r_tmo_cnt <= {TMO_W{1'b0}};
    end
  end
`endif

  assign coin_accept = r_coin_accept;
  assign coin_reject = r_coin_reject;
  assign sel_nak     = r_sel_nak;
  assign disp_req    = r_disp_req;
  assign chg_valid   = r_chg_valid;
  assign chg_coin    = r_chg_coin;
  assign credit      = r_credit;
  assign busy        = r_busy;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Scoreboard bench for vend_txn_ctrl: directed plan sequences plus random traffic,
// checked against a transaction-level model of credit, mode and change payout.
module tb_vend_txn_ctrl;
  localparam int PRICE = 30;
  localparam int MAXC  = 100;
  localparam int CW    = 8;
  localparam int TMO   = 8;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          coin_valid = 1'b0, sel = 1'b0, cancel = 1'b0, disp_ack = 1'b0, chg_ready = 1'b0;
  logic [1:0]    coin = 2'b00;
  logic          coin_accept, coin_reject, sel_nak, disp_req, chg_valid, busy;
  logic [1:0]    chg_coin;
  logic [CW-1:0] credit;

  always #5 clk = ~clk;

  vend_txn_ctrl #(.PRICE(PRICE), .MAX_CREDIT(MAXC), .CREDIT_W(CW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin(coin),
    .coin_accept(coin_accept), .coin_reject(coin_reject), .sel(sel), .sel_nak(sel_nak),
    .cancel(cancel), .disp_req(disp_req), .disp_ack(disp_ack), .chg_valid(chg_valid),
    .chg_coin(chg_coin), .chg_ready(chg_ready), .credit(credit), .busy(busy)
  );

  typedef struct {
    int credit;
    bit busy;
    bit disp;
    bit chgv;
    int chgc;
  } exp_t;

  exp_t q_exp[$];
  bit   q_coin[$];
  bit   q_nak[$];
  int   q_chg[$];

  int n_checks = 0, n_pass = 0;
  bit mon_en = 1'b0;
  // Model: mode 0 = open for coins (IDLE/CREDIT), 1 = dispensing, 2 = paying change
  int m_credit = 0, m_mode = 0, m_idle = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int units(input bit [1:0] c);
    int tbl[4] = '{0, 5, 10, 25};
    return tbl[c];
  endfunction

  function automatic int greedy(input int c);
    int den[3] = '{25, 10, 5};
    foreach (den[i]) if (den[i] <= c) return den[i];
    return 0;
  endfunction

  function automatic int code_of(input int u);
    for (int k = 0; k < 4; k++) if (units(2'(k)) == u) return k;
    return 0;
  endfunction

  task automatic model_step(input bit cv, input bit [1:0] cc, input bit s, input bit cn,
                            input bit ack, input bit rdy);
    exp_t e;
    int v = units(cc);
    bit in_credit = (m_mode == 0) && (m_credit > 0);
    bit quiet = !cv && !s && !cn;
    int g;
    case (m_mode)
      0: begin
        if (cn) begin
          if (cv) q_coin.push_back(1'b0);
          if (m_credit > 0) m_mode = 2;
        end else if (s && m_credit >= PRICE) begin
          if (cv) q_coin.push_back(1'b0);
          m_credit -= PRICE;
          m_mode = 1;
        end else begin
          if (s) q_nak.push_back(1'b1);
          if (cv) begin
            if (v > 0 && m_credit + v <= MAXC) begin
              q_coin.push_back(1'b1);
              m_credit += v;
            end else q_coin.push_back(1'b0);
          end
        end
      end
      1: begin
        if (cv) q_coin.push_back(1'b0);
        if (ack) m_mode = (m_credit > 0) ? 2 : 0;
      end
      default: begin
        if (cv) q_coin.push_back(1'b0);
        if (rdy) begin
          g = greedy(m_credit);
          q_chg.push_back(code_of(g));
          m_credit -= g;
          if (m_credit == 0) m_mode = 0;
        end
      end
    endcase
`ifdef VEND_TIMEOUT_EN
    if (in_credit && quiet && m_mode == 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_mode = 2;
        m_idle = 0;
      end
    end else m_idle = 0;
`else
    m_idle = (in_credit && quiet) ? m_idle + 1 : 0;
`endif
    e.credit = m_credit;
    e.busy   = (m_mode != 0);
    e.disp   = (m_mode == 1);
    e.chgv   = (m_mode == 2);
    e.chgc   = e.chgv ? code_of(greedy(m_credit)) : 0;
    q_exp.push_back(e);
  endtask

  task automatic cycle(input bit cv, input bit [1:0] cc, input bit s, input bit cn,
                       input bit ack, input bit rdy);
    @(posedge clk);
    #3;
    coin_valid = cv; coin = cc; sel = s; cancel = cn; disp_ack = ack; chg_ready = rdy;
    model_step(cv, cc, s, cn, ack, rdy);
    mon_en = 1'b1;
  endtask

  task automatic put_coin(input bit [1:0] cc);
    cycle(1'b1, cc, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input bit ack, input bit rdy);
    repeat (n) cycle(1'b0, 2'b00, 1'b0, 1'b0, ack, rdy);
  endtask

  // Per-cycle state monitor plus coin/nak pulse scoreboard
  always begin
    exp_t e;
    bit b;
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (q_exp.size() == 0) chk("exp_queue_nonempty", q_exp.size(), 1);
      else begin
        e = q_exp.pop_front();
        chk("credit", int'(credit), e.credit);
        chk("busy", int'(busy), int'(e.busy));
        chk("disp_req", int'(disp_req), int'(e.disp));
        chk("chg_valid", int'(chg_valid), int'(e.chgv));
        if (e.chgv) chk("chg_coin", int'(chg_coin), e.chgc);
      end
      if (coin_accept || coin_reject) begin
        if (q_coin.size() == 0) chk("coin_pulse_expected", q_coin.size(), 1);
        else begin
          b = q_coin.pop_front();
          chk("coin_accept", int'(coin_accept), int'(b));
          chk("coin_reject", int'(coin_reject), int'(!b));
        end
      end
      if (sel_nak) begin
        chk("sel_nak_expected", q_nak.size(), 1);
        if (q_nak.size() > 0) void'(q_nak.pop_front());
      end
    end
  end

  // Change handshake scoreboard, sampled mid-cycle while inputs are stable
  always @(negedge clk) begin
    if (mon_en && chg_valid && chg_ready) begin
      if (q_chg.size() == 0) chk("chg_handshake_expected", q_chg.size(), 1);
      else chk("chg_paid_coin", int'(chg_coin), q_chg.pop_front());
    end
  end

  task automatic mid_reset();
    @(posedge clk);
    #4;
    chk("pre_rst_chg_valid", int'(chg_valid), 1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("rst_chg_valid", int'(chg_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_credit", int'(credit), 0);
    chk("rst_disp_req", int'(disp_req), 0);
    q_exp.delete(); q_coin.delete(); q_nak.delete(); q_chg.delete();
    m_credit = 0; m_mode = 0; m_idle = 0;
    coin_valid = 1'b0; sel = 1'b0; cancel = 1'b0; disp_ack = 1'b0; chg_ready = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("reset_credit", int'(credit), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_disp_req", int'(disp_req), 0);
    chk("reset_chg_valid", int'(chg_valid), 0);
    chk("reset_coin_accept", int'(coin_accept), 0);
    chk("reset_coin_reject", int'(coin_reject), 0);
    chk("reset_sel_nak", int'(sel_nak), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Buy with change: 10 + 25, select, dispense, 5 back
    put_coin(2'b10); put_coin(2'b11);
    cycle(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);
    idle(3, 1'b0, 1'b1);
    // Full refund of 40 as 25, 10, 5
    put_coin(2'b11); put_coin(2'b10); put_coin(2'b01);
    cycle(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(4, 1'b0, 1'b1);
    // Ceiling: 90 then 25 rejected, invalid code rejected
    put_coin(2'b11); put_coin(2'b11); put_coin(2'b11); put_coin(2'b10); put_coin(2'b01);
    put_coin(2'b11); put_coin(2'b00);
    cycle(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(6, 1'b0, 1'b1);
    // Hopper stall on 35
    put_coin(2'b11); put_coin(2'b10);
    cycle(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(5, 1'b0, 1'b0);
    idle(3, 1'b0, 1'b1);
    // Exact price with same-cycle coin; then short credit nak
    put_coin(2'b11); put_coin(2'b01);
    cycle(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);
    put_coin(2'b10); put_coin(2'b10);
    cycle(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b0, 1'b1);
    // Idle credit of 15: held, or refunded by the timeout build
    put_coin(2'b10); put_coin(2'b01);
    idle(TMO + 4, 1'b0, 1'b1);
    cycle(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(4, 1'b0, 1'b1);
    // Reset while paying change
    put_coin(2'b11); put_coin(2'b10);
    cycle(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);
    mid_reset();

    for (int i = 0; i < 800; i++) begin
      cycle(($urandom % 3) == 0, 2'($urandom), ($urandom % 6) == 0, ($urandom % 15) == 0,
            ($urandom % 3) == 0, ($urandom % 2) == 0);
    end
    repeat (40) cycle(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(3, 1'b0, 1'b0);

    @(posedge clk);
    #2;
    chk("exp_queue_drained", q_exp.size(), 0);
    chk("coin_queue_drained", q_coin.size(), 0);
    chk("nak_queue_drained", q_nak.size(), 0);
    chk("chg_queue_drained", q_chg.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/vend_txn_ctrl.md
Name: vend_txn_ctrl

Overview:
- Transaction controller that sequences one vend cycle for the coin-operated vending datapath.
- Accepts coins (5/10/25 units) and accumulates credit; on an item selection with sufficient credit, requests one dispense, then pays out change coin-by-coin to the change hopper.
- Supports cancel/refund.
- Sits between the coin acceptor, the item dispenser and the change hopper.

Parameters:
- PRICE, 30, item price in units (multiple of 5).
- MAX_CREDIT, 100, credit ceiling in units (multiple of 5, ≥ PRICE); a coin that would exceed it is rejected.
- CREDIT_W, 8, credit register width; must hold MAX_CREDIT.
- TIMEOUT_CYC, 1000, idle cycles before auto-refund (used only with the optional feature).

Ports:
- clk, in, 1: system clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- coin_valid, in, 1: coin present this cycle.
- coin, in, 2: coin code; 01=5, 10=10, 11=25, 00=invalid.
- coin_accept, out, 1: one-cycle pulse, coin credited.
- coin_reject, out, 1: one-cycle pulse, coin returned.
- sel, in, 1: item selection request, level-sampled.
- sel_nak, out, 1: one-cycle pulse, selection refused.
- cancel, in, 1: refund request, level-sampled.
- disp_req, out, 1: dispense request, held until acknowledged.
- disp_ack, in, 1: dispenser done.
- chg_valid, out, 1: change coin offered.
- chg_coin, out, 2: change coin code, same encoding as coin.
- chg_ready, in, 1: hopper accepts chg_coin.
- credit, out, CREDIT_W: current credit, registered.
- busy, out, 1: high in DISPENSE or CHANGE.

Behaviour:
- Reset (async, rst_n=0): state IDLE, credit=0, all outputs 0. Reset mid-transaction discards credit and drops disp_req/chg_valid immediately.
- States: IDLE (credit=0), CREDIT (credit>0), DISPENSE, CHANGE.
- Coins, IDLE/CREDIT:
  - A valid code with credit+value ≤ MAX_CREDIT updates credit on that edge; coin_accept pulses the next cycle.
  - Otherwise coin_reject pulses the next cycle.
  - coin=00 is always rejected.
  - IDLE→CREDIT when credit becomes nonzero.
- Coins, DISPENSE/CHANGE: always rejected.
- sel in IDLE/CREDIT, compared against the pre-edge credit:
  - credit ≥ PRICE: credit -= PRICE on that edge, go to DISPENSE, disp_req=1 from the next cycle.
  - Otherwise sel_nak pulses and the state is unchanged.
- Same-cycle events:
  - coin with successful sel: coin rejected.
  - cancel with sel: cancel wins, sel ignored with no nak.
  - coin with cancel: coin rejected.
- DISPENSE:
  - disp_req held until disp_ack is sampled high.
  - Then go to CHANGE if credit>0, else IDLE.
  - cancel is ignored.
  - disp_ack outside DISPENSE is ignored.
- cancel in CREDIT: go to CHANGE (full refund). cancel in IDLE: ignored.
- CHANGE:
  - chg_valid=1; chg_coin = largest coin ≤ credit (greedy order 25, 10, 5).
  - On chg_valid && chg_ready, credit -= value and the next coin is presented the following cycle.
  - chg_coin is stable while chg_valid && !chg_ready.
  - When credit reaches 0, chg_valid drops and the state goes to IDLE.
- Arithmetic: credit is unsigned, always a multiple of 5, never negative or above MAX_CREDIT.
- Latency: coin to credit update, 1 edge; sel to disp_req, 1 cycle; one change coin per accepted handshake, back-to-back allowed.

Optional Feature:
- Macro VEND_TIMEOUT_EN.
- Defined:
  - A counter runs in CREDIT and resets on any coin_valid, sel or cancel.
  - When it reaches TIMEOUT_CYC, the block enters CHANGE and refunds as for cancel.
  - The counter is cleared in all other states.
- Undefined: no counter; credit is held indefinitely in CREDIT.

Decomposition:
- Package vend_pkg:
  - coin code constants (COIN_NONE/5/10/25);
  - coin value function, code→units;
  - state enum (IDLE, CREDIT, DISPENSE, CHANGE).
- Sub-module vend_change_sel: combinational greedy selector, credit in → chg_coin and coin value out. Reused by the refund path.

Test Plan:
- Coins 10 then 25, then sel → credit 10, 35; disp_req; after disp_ack, change 5 (chg_coin=01); credit 0, IDLE.
- Coins 25, 10, 5, then cancel → change sequence 11, 10, 01 with chg_ready=1; 3 handshakes, then IDLE.
- Credit 90, coin 25 → coin_reject; credit stays 90. coin=00 with coin_valid → coin_reject.
- Credit 35 in CHANGE, chg_ready held low 5 cycles → chg_valid=1 and chg_coin=11 stable; then ready → 25 paid, next coin 10.
- Credit 30, coin 5 and sel in the same cycle → coin_reject, DISPENSE, credit 0. Credit 20, sel → sel_nak, state CREDIT.
- rst_n low mid-CHANGE → chg_valid, busy, credit 0 immediately. With VEND_TIMEOUT_EN, TIMEOUT_CYC=8, credit 15 idle 8 cycles → refund 10, 5.
